// File: rtl/cpu_bus_bridge.sv
// CPU byte bus to 32-bit word bus bridge with a stall-by-ce handshake.
// Define CPU_BUS_BRIDGE_PREFETCH_EN to add a one-word read line buffer.
module cpu_bus_bridge (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [7:0]  out,
  input  logic        we,
  output logic [7:0]  in,
  output logic        ce,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    SAMPLE,
    BUSY,
    GRANT
  } state_e;

  state_e      state_q, state_d;
  logic        ce_q, ce_d;
  logic [7:0]  in_q, in_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        hit;
  logic [7:0]  hit_byte;
  logic [7:0]  rd_byte;
  logic        ack_edge;

  assign rd_byte  = mem_rdata[{address[1:0], 3'b000} +: 8];
  assign ack_edge = (state_q == BUSY) && mem_ack;

`ifdef CPU_BUS_BRIDGE_PREFETCH_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;

  assign hit      = buf_valid_q && (buf_tag_q == address[31:2]);
  assign hit_byte = buf_data_q[{address[1:0], 3'b000} +: 8];

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (ack_edge) begin
      if (!mem_we_q) begin
        buf_valid_d = 1'b1;
        buf_tag_d   = mem_addr_q[31:2];
        buf_data_d  = mem_rdata;
      end else if (buf_valid_q && (buf_tag_q == mem_addr_q[31:2])) begin
        // write-through keeps the line coherent with memory
        for (int i = 0; i < 4; i++) begin
          if (mem_be_q[i]) buf_data_d[8*i +: 8] = mem_wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_byte = 8'h00;
`endif

  always_comb begin
    state_d     = state_q;
    ce_d        = ce_q;
    in_d        = in_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      SAMPLE: begin
        if (!we && hit) begin
          in_d    = hit_byte;
          ce_d    = 1'b1;
          state_d = GRANT;
        end else begin
          mem_addr_d  = {address[31:2], 2'b00};
          mem_we_d    = we;
          mem_be_d    = we ? (4'b0001 << address[1:0]) : 4'b1111;
          mem_wdata_d = {4{out}};
          mem_req_d   = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ce_d      = 1'b1;
          state_d   = GRANT;
          if (!mem_we_q) in_d = rd_byte;
        end
      end
      GRANT: begin
        ce_d    = 1'b0;
        state_d = SAMPLE;
      end
      default: begin
        ce_d      = 1'b0;
        mem_req_d = 1'b0;
        state_d   = SAMPLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SAMPLE;
      ce_q        <= 1'b0;
      in_q        <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      in_q        <= in_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in        = in_q;
  assign ce        = ce_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
